// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with bubble collapse, flush and occupancy count
module pipe_stage_chain #(
    parameter int DATA_W = 104,
    parameter int CTRL_W = 3,
    parameter int DEPTH = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  occupancy
);
    localparam logic [DATA_W-1:0] PAY_MASK = {DATA_W{1'b1}} >> CTRL_W;

    logic [DEPTH:0]      adv;
    logic [DEPTH-1:0]    v;
    logic [DEPTH-1:0]    v_nxt;
    logic [DATA_W-1:0]   d [DEPTH];
    logic [DATA_W-1:0]   d_nxt [DEPTH];
    logic [CNT_W-1:0]    cnt_nxt;
    logic                push;
    logic                src_v;
    logic [DATA_W-1:0]   src_d;

    // ready ripples back from the output; an empty stage always advances
    always_comb begin
        adv[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) adv[k] = !v[k] || adv[k + 1];
    end

    assign in_ready  = adv[0] && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // per-stage next state: shift on advance, bubbles and kills carry a zero control field
    always_comb begin
        cnt_nxt = '0;
        src_v   = 1'b0;
        src_d   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            src_v    = (k == 0) ? push : v[(k == 0) ? 0 : k - 1];
            src_d    = (k == 0) ? in_data : d[(k == 0) ? 0 : k - 1];
            v_nxt[k] = (rst || flush) ? 1'b0 : adv[k] ? src_v : v[k];
            d_nxt[k] = rst ? '0
                     : (!flush && adv[k] && src_v) ? src_d
                     : (flush || adv[k]) ? (d[k] & PAY_MASK)
                     : d[k];
            cnt_nxt  = cnt_nxt + CNT_W'(v_nxt[k]);
        end
    end

    // stage registers and occupancy move together so the count always matches v
    always_ff @(posedge clk) begin
        v         <= v_nxt;
        d         <= d_nxt;
        occupancy <= cnt_nxt;
    end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: scoreboard bench driving a DEPTH=3 and a DEPTH=1 chain with shared stimulus
module tb_pipe_stage_chain;
    localparam int W  = 104;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         flush;
    logic [W-1:0] in_data;
    int           checks = 0;
    int           fails  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int D  = (g == 0) ? 3 : 1;
        localparam int CN = $clog2(D + 1);
        logic          ir;
        logic          ov;
        logic [W-1:0]  od;
        logic [CN-1:0] occ;
        logic [W-1:0]  qd [$];
        int            qp [$];
        bit            live = 1'b0;

        pipe_stage_chain #(.DATA_W(W), .CTRL_W(CW), .DEPTH(D)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir), .in_data(in_data),
            .out_valid(ov), .out_ready(out_ready), .out_data(od), .flush(flush), .occupancy(occ)
        );

        // bundles queue up in arrival order; each one's stage is bounded by how many sit ahead of it
        always @(negedge clk) begin
            automatic bit hv = qd.size() > 0 && qp[0] == D - 1;
            automatic bit xr = !flush && (qd.size() < D || out_ready);
            if (live) begin
                chk($sformatf("d%0d_out_valid", D), W'(ov), W'(hv));
                chk($sformatf("d%0d_occupancy", D), W'(occ), W'(qd.size()));
                chk($sformatf("d%0d_in_ready", D), W'(ir), W'(xr));
                if (!ov) chk($sformatf("d%0d_bubble_ctrl", D), W'(od[W-1 -: CW]), '0);
                if (ov && out_ready && !rst) begin
                    if (qd.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL d%0d_out_data: got %h expected nothing (scoreboard empty)", D, od);
                    end else chk($sformatf("d%0d_out_data", D), od, qd[0]);
                end
            end
            if (rst) begin
                qd.delete();
                qp.delete();
                live = 1'b1;
            end else begin
                if (hv && out_ready) begin
                    void'(qd.pop_front());
                    void'(qp.pop_front());
                end
                if (flush) begin
                    qd.delete();
                    qp.delete();
                end else begin
                    for (int i = 0; i < qp.size(); i++)
                        qp[i] = (qp[i] + 1 < D - 1 - i) ? qp[i] + 1 : D - 1 - i;
                    if (in_valid && xr) begin
                        qd.push_back(in_data);
                        qp.push_back(0);
                    end
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] dat, input logic ordy,
                         input logic fl, input logic r);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a;
        a         = {13{8'hA5}};
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = '1;
        out_ready = 1'b0;
        flush     = 1'b0;
        drive(1'b1, '1, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1);
        @(negedge clk);
        chk("d3_reset_out_data", ch[0].od, '0);
        chk("d1_reset_out_data", ch[1].od, '0);
        drive(1'b1, a, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 5);
        for (int i = 0; i < 6; i++) drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        idle(1'b1, 6);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 5);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        drive(1'b1, rnd(), 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1);
        drive(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
        idle(1'b1, 5);
        drive(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
        idle(1'b1, 4);
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
        idle(1'b1, 6);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
